// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_pkg;

    localparam int MULTI_CNT_W = 6;
    localparam int WAIT_CNT_W  = 8;
    localparam int MEM_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MULTI    = 2'd2
    } state_t;

    // Value loaded into the MULTI counter: a latency of 0 still costs one stall cycle.
    function automatic logic [MULTI_CNT_W-1:0] multi_load(input logic [MULTI_CNT_W-1:0] lat);
        return (lat == '0) ? '0 : lat - MULTI_CNT_W'(1);
    endfunction

endpackage

// File: rtl/stall_cnt.sv
// rtl/stall_cnt.sv - loadable down-counter with zero flag for multi-cycle stalls
module stall_cnt
    import pipe_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [MULTI_CNT_W-1:0] load_val,
    input  logic                   dec,
    output logic                   zero
);

    logic [MULTI_CNT_W-1:0] count;

    // Load takes precedence; decrement stops at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - MULTI_CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall, flush and redirect control for a five-stage pipeline
module pipe_hazard_ctrl
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] dec_rs1,
    input  logic [4:0] dec_rs2,
    input  logic       dec_use_rs1,
    input  logic       dec_use_rs2,
    input  logic [4:0] exe_rd,
    input  logic       exe_memr,
    input  logic       exe_regw,
    input  logic       exe_branch_taken,
    input  logic       exe_multi,
    input  logic [5:0] multi_lat,
    input  logic       mem_req,
    input  logic       mem_ack,
    output logic       if_enable,
    output logic       ifid_enable,
    output logic       idex_enable,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       pc_redirect,
    output logic       err_timeout,
    output logic [1:0] state_o
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_VAL = WAIT_CNT_W'(MEM_TIMEOUT);

    state_t                state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  mem_stall;
    logic                  load_use;
    logic                  stall;
    logic                  cnt_load;
    logic                  cnt_dec;
    logic                  cnt_zero;

    assign mem_stall = mem_req && !mem_ack;

    assign load_use = exe_memr && exe_regw && (exe_rd != 5'd0) &&
                      ((dec_use_rs1 && (dec_rs1 == exe_rd)) ||
                       (dec_use_rs2 && (dec_rs2 == exe_rd)));

    // Whole-pipe stall: in RUN a mem miss or a new multi-cycle op, otherwise the wait state's own condition.
    always_comb begin
        stall = 1'b0;
        case (state)
            ST_RUN:      stall = mem_stall || exe_multi;
            ST_MEM_WAIT: stall = !mem_ack;
            ST_MULTI:    stall = !cnt_zero;
            default:     stall = 1'b0;
        endcase
    end

    assign cnt_load = (state == ST_RUN) && !mem_stall && exe_multi;
    assign cnt_dec  = (state == ST_MULTI) && !cnt_zero;

    stall_cnt u_stall_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (multi_load(multi_lat)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Output priority: stall freezes everything, a taken branch squashes the wrong path, then load-use bubble.
    always_comb begin
        if_enable   = 1'b1;
        ifid_enable = 1'b1;
        idex_enable = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        pc_redirect = 1'b0;
        if (stall) begin
            if_enable   = 1'b0;
            ifid_enable = 1'b0;
            idex_enable = 1'b0;
        end else if (exe_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            pc_redirect = 1'b1;
        end else if (load_use) begin
            if_enable   = 1'b0;
            ifid_enable = 1'b0;
            idex_flush  = 1'b1;
        end
    end

    // State machine with the memory wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    wait_cnt <= '0;
                    if (mem_stall) begin
                        state <= ST_MEM_WAIT;
                    end else if (exe_multi) begin
                        state <= ST_MULTI;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_ack) begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt != TIMEOUT_VAL) begin
                        wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
                        if (wait_cnt == TIMEOUT_VAL - WAIT_CNT_W'(1)) begin
                            err_timeout <= 1'b1;
                        end
                    end
                end
                ST_MULTI: begin
                    if (cnt_zero) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] dec_rs1, dec_rs2, exe_rd;
    logic       dec_use_rs1, dec_use_rs2, exe_memr, exe_regw;
    logic       exe_branch_taken, exe_multi, mem_req, mem_ack;
    logic [5:0] multi_lat;
    logic       if_enable, ifid_enable, idex_enable, ifid_flush, idex_flush, pc_redirect;
    logic       err_timeout;
    logic [1:0] state_o;
    logic [5:0] outs;

    int n_checks = 0;
    int n_fail   = 0;

    // {if_enable, ifid_enable, idex_enable, ifid_flush, idex_flush, pc_redirect}
    localparam logic [5:0] O_RUN   = 6'b111000;
    localparam logic [5:0] O_STALL = 6'b000000;
    localparam logic [5:0] O_LU    = 6'b001010;
    localparam logic [5:0] O_BR    = 6'b111111;

    always #5 clk = ~clk;

    assign outs = {if_enable, ifid_enable, idex_enable, ifid_flush, idex_flush, pc_redirect};

    pipe_hazard_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .dec_rs1          (dec_rs1),
        .dec_rs2          (dec_rs2),
        .dec_use_rs1      (dec_use_rs1),
        .dec_use_rs2      (dec_use_rs2),
        .exe_rd           (exe_rd),
        .exe_memr         (exe_memr),
        .exe_regw         (exe_regw),
        .exe_branch_taken (exe_branch_taken),
        .exe_multi        (exe_multi),
        .multi_lat        (multi_lat),
        .mem_req          (mem_req),
        .mem_ack          (mem_ack),
        .if_enable        (if_enable),
        .ifid_enable      (ifid_enable),
        .idex_enable      (idex_enable),
        .ifid_flush       (ifid_flush),
        .idex_flush       (idex_flush),
        .pc_redirect      (pc_redirect),
        .err_timeout      (err_timeout),
        .state_o          (state_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0;
        exe_rd = 5'd0; exe_memr = 1'b0; exe_regw = 1'b0; exe_branch_taken = 1'b0;
        exe_multi = 1'b0; multi_lat = 6'd0; mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    // Advance to the next cycle; inputs applied after this are seen for that whole cycle.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic expect_cyc(input string tag, input logic [5:0] o, input logic [1:0] st);
        #2;
        check({tag, "_out"}, 32'(outs), 32'(o));
        check({tag, "_st"}, 32'(state_o), 32'(st));
    endtask

    initial begin
        idle();
        reset = 1'b0;
        #2;
        check("rst_out", 32'(outs), 32'(O_RUN));
        check("rst_st", 32'(state_o), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        tick(); reset = 1'b1;

        // Load-use hazards
        tick(); idle(); exe_memr = 1; exe_regw = 1; exe_rd = 5'd5; dec_rs2 = 5'd5; dec_use_rs2 = 1;
        expect_cyc("lu_rs2", O_LU, 2'd0);
        tick(); idle();
        expect_cyc("lu_after", O_RUN, 2'd0);
        tick(); idle(); exe_memr = 1; exe_regw = 1; exe_rd = 5'd0; dec_rs2 = 5'd0; dec_use_rs2 = 1;
        expect_cyc("lu_rd0", O_RUN, 2'd0);
        tick(); idle(); exe_memr = 1; exe_regw = 1; exe_rd = 5'd9; dec_rs1 = 5'd9; dec_use_rs1 = 0;
        expect_cyc("lu_nouse", O_RUN, 2'd0);
        dec_use_rs1 = 1;
        expect_cyc("lu_rs1", O_LU, 2'd0);
        exe_regw = 0;
        expect_cyc("lu_noregw", O_RUN, 2'd0);

        // Memory wait: three stall cycles then ack
        tick(); idle(); mem_req = 1; mem_ack = 1;
        expect_cyc("mem_hit", O_RUN, 2'd0);
        mem_ack = 0;
        expect_cyc("mem_s1", O_STALL, 2'd0);
        tick(); expect_cyc("mem_s2", O_STALL, 2'd1);
        tick(); expect_cyc("mem_s3", O_STALL, 2'd1);
        tick(); mem_ack = 1;
        expect_cyc("mem_ack", O_RUN, 2'd1);
        tick(); idle();
        expect_cyc("mem_done", O_RUN, 2'd0);

        // Multi-cycle op, latency 4 held high through release
        tick(); exe_multi = 1; multi_lat = 6'd4;
        expect_cyc("mul4_s1", O_STALL, 2'd0);
        for (int i = 2; i <= 4; i++) begin
            tick(); expect_cyc($sformatf("mul4_s%0d", i), O_STALL, 2'd2);
        end
        tick(); expect_cyc("mul4_rel", O_RUN, 2'd2);
        tick(); idle();
        expect_cyc("mul4_run", O_RUN, 2'd0);

        // Multi latency 0 costs one stall
        tick(); exe_multi = 1; multi_lat = 6'd0;
        expect_cyc("mul0_s1", O_STALL, 2'd0);
        tick(); expect_cyc("mul0_rel", O_RUN, 2'd2);
        tick(); idle();
        expect_cyc("mul0_run", O_RUN, 2'd0);

        // Branch during MULTI held until release
        tick(); exe_multi = 1; multi_lat = 6'd3;
        expect_cyc("brm_s1", O_STALL, 2'd0);
        tick(); exe_branch_taken = 1;
        expect_cyc("brm_s2", O_STALL, 2'd2);
        tick(); expect_cyc("brm_s3", O_STALL, 2'd2);
        tick(); expect_cyc("brm_rel", O_BR, 2'd2);
        tick(); idle();
        expect_cyc("brm_run", O_RUN, 2'd0);

        // Branch masks load-use
        tick(); exe_memr = 1; exe_regw = 1; exe_rd = 5'd7; dec_rs1 = 5'd7; dec_use_rs1 = 1; exe_branch_taken = 1;
        expect_cyc("br_lu", O_BR, 2'd0);

        // Branch during mem stall honoured on ack
        tick(); idle(); mem_req = 1; exe_branch_taken = 1;
        expect_cyc("brw_s1", O_STALL, 2'd0);
        tick(); mem_ack = 1;
        expect_cyc("brw_ack", O_BR, 2'd1);
        tick(); idle();
        expect_cyc("brw_run", O_RUN, 2'd0);

        // Mem stall and multi together: memory first, multi afterwards
        tick(); mem_req = 1; exe_multi = 1; multi_lat = 6'd2;
        expect_cyc("mm_s1", O_STALL, 2'd0);
        tick(); mem_ack = 1;
        expect_cyc("mm_ack", O_RUN, 2'd1);
        tick(); mem_req = 0; mem_ack = 0;
        expect_cyc("mm_mul1", O_STALL, 2'd0);
        tick(); expect_cyc("mm_mul2", O_STALL, 2'd2);
        tick(); expect_cyc("mm_rel", O_RUN, 2'd2);
        tick(); idle();
        expect_cyc("mm_run", O_RUN, 2'd0);

        // Timeout: long memory wait
        tick(); mem_req = 1;
        expect_cyc("to_s0", O_STALL, 2'd0);
        for (int i = 1; i <= 260; i++) begin
            tick();
            #2;
            if (i == 255) check("to_err_before", 32'(err_timeout), 32'd0);
            if (i == 256) check("to_err_set", 32'(err_timeout), 32'd1);
            if (i == 260) begin
                check("to_err_held", 32'(err_timeout), 32'd1);
                check("to_out", 32'(outs), 32'(O_STALL));
                check("to_st", 32'(state_o), 32'd1);
            end
        end
        tick(); mem_ack = 1;
        expect_cyc("to_ack", O_RUN, 2'd1);
        tick(); idle();
        expect_cyc("to_run", O_RUN, 2'd0);
        check("to_sticky", 32'(err_timeout), 32'd1);
        reset = 1'b0;
        #1;
        check("to_rst_err", 32'(err_timeout), 32'd0);
        tick(); reset = 1'b1;

        // Reset in MULTI with cnt=3
        tick(); exe_multi = 1; multi_lat = 6'd5;
        expect_cyc("rm_s1", O_STALL, 2'd0);
        tick(); expect_cyc("rm_cnt4", O_STALL, 2'd2);
        tick(); expect_cyc("rm_cnt3", O_STALL, 2'd2);
        idle();
        reset = 1'b0;
        #1;
        check("rm_out", 32'(outs), 32'(O_RUN));
        check("rm_st", 32'(state_o), 32'd0);
        check("rm_err", 32'(err_timeout), 32'd0);
        tick(); reset = 1'b1;
        tick(); expect_cyc("rm_after", O_RUN, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
